debounce_fsm: RTL

//   Multi-channel switch/button debouncer; consumer of the debounce_counter
//   10 ms strobe (ms10_tick). Each channel runs a 4-state FSM that accepts a

---
 rtl/debounce_fsm_if.sv | 23 ++
 rtl/debounce_fsm.sv | 102 ++++++++++
 2 files changed

// File: rtl/debounce_fsm_if.sv
// Signal bundle for debounce_fsm: raw switches and tick in, clean levels and press pulses out.
// state_dbg packs each channel's 2-bit FSM state, channel i in bits [2*i+1:2*i].
interface debounce_fsm_if #(
  parameter int W = 4
);
  // No valid/ready handshake: ms10_tick is a single-cycle strobe, sw is a level,
  // db_level is a level, and db_tick is a single-cycle strobe per accepted press.
  logic           ms10_tick;
  logic [W-1:0]   sw;
  logic [W-1:0]   db_level;
  logic [W-1:0]   db_tick;
  logic [2*W-1:0] state_dbg;

  modport master (
    output ms10_tick, sw,
    input  db_level, db_tick, state_dbg
  );

  modport slave (
    input  ms10_tick, sw,
    output db_level, db_tick, state_dbg
  );
endinterface

// File: rtl/debounce_fsm.sv
// Multi-channel debouncer: a change is accepted only after STAGES stable ms10_tick periods.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-FF synchronizer on every sw bit.
module debounce_fsm #(
  parameter int W      = 4,
  parameter int STAGES = 3
) (
  input  logic          clk,
  input  logic          reset,
  debounce_fsm_if.slave bus
);
  localparam int CW = $clog2(STAGES + 1);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  state_t          state [W];
  logic   [CW-1:0] cnt   [W];
  logic   [W-1:0]  s;
  logic   [W-1:0]  db_level_q;
  logic   [W-1:0]  db_tick_q;

`ifdef DEBOUNCE_SYNC_EN
  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.sw;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = bus.sw;
`endif

  // db_level only moves on acceptance, so it always equals (state in {ONE, WAIT0}).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < W; i++) begin
        state[i] <= ZERO;
        cnt[i]   <= '0;
      end
      db_level_q <= '0;
      db_tick_q  <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        db_tick_q[i] <= 1'b0;
        case (state[i])
          ZERO: begin
            if (s[i]) begin
              state[i] <= WAIT1;
              cnt[i]   <= CW'(STAGES);
            end
          end
          WAIT1: begin
            if (!s[i]) begin
              state[i] <= ZERO;
            end else if (bus.ms10_tick) begin
              if (cnt[i] == CW'(1)) begin
                state[i]      <= ONE;
                db_level_q[i] <= 1'b1;
                db_tick_q[i]  <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] - CW'(1);
              end
            end
          end
          ONE: begin
            if (!s[i]) begin
              state[i] <= WAIT0;
              cnt[i]   <= CW'(STAGES);
            end
          end
          WAIT0: begin
            if (s[i]) begin
              state[i] <= ONE;
            end else if (bus.ms10_tick) begin
              if (cnt[i] == CW'(1)) begin
                state[i]      <= ZERO;
                db_level_q[i] <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] - CW'(1);
              end
            end
          end
          default: state[i] <= ZERO;
        endcase
      end
    end
  end

  assign bus.db_level = db_level_q;
  assign bus.db_tick  = db_tick_q;

  for (genvar g = 0; g < W; g++) begin : g_dbg
    assign bus.state_dbg[2*g +: 2] = state[g];
  end
endmodule
